// File: rtl/tc_pkg.sv
// Shared types and constants for the tensor-core front end (token embedder and its FIFO).
package tc_pkg;

    typedef enum logic [2:0] {
        EMB_IDLE,
        EMB_TOK_RD,
        EMB_TOK_CHK,
        EMB_RD,
        EMB_DRAIN
    } embedder_state_t;

    // Token id that terminates a run.
    localparam int unsigned TOK_EOS = 0;

    // Depth of the embedder output FIFO; the read-issue credit check relies on this being 2.
    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/emb_out_fifo.sv
// Two-entry output FIFO for the token embedder. Each entry carries one embedding element plus
// its row-end flag. The head entry stays put until popped, so the bus holds under backpressure.
module emb_out_fifo
    import tc_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             not_empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_push;
    logic             do_pop;

    // Guard against pushing into a full FIFO or popping an empty one.
    always_comb begin
        do_push = push && (count_q != 2'(FIFO_DEPTH));
        do_pop  = pop && (count_q != 2'd0);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage, pointers and occupancy; reset flushes everything to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign not_empty = (count_q != 2'd0);

endmodule

// File: rtl/token_embedder.sv
// Token embedder: walks the encoder's token RAM from tok_base until EOS, fetches each token's
// embedding row from a synchronous SRAM and streams the elements on a valid/ready bus.
module token_embedder
    import tc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned EMB_DIM        = 4,
    parameter int unsigned VOCAB_SIZE     = 16,
    parameter int unsigned EMB_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     tok_base,
    output logic [ADDR_WIDTH-1:0]     tok_addr,
    input  logic [DATA_WIDTH-1:0]     tok_data,
    output logic [EMB_ADDR_WIDTH-1:0] emb_addr,
    input  logic [DATA_WIDTH-1:0]     emb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH:0]       tok_count,
    output logic                      err
);

    localparam int unsigned IDX_W = $clog2(EMB_DIM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EMB_DIM - 1);
    // Run limit when the RAM holds no EOS: one pass over every address.
    localparam logic [ADDR_WIDTH:0] TOK_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    embedder_state_t       state_q, state_d;
    logic [ADDR_WIDTH-1:0] tok_addr_q, tok_addr_d;
    logic [ADDR_WIDTH:0]   tok_count_q, tok_count_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] id_q, id_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  zero_q, zero_d;        // current token is out of vocabulary
    logic                  inflight_q, inflight_d; // element requested last cycle lands now
    logic                  pend_last_q, pend_last_d;
    logic                  pend_zero_q, pend_zero_d;

    logic                  issue;
    logic                  pop;
    logic [1:0]            fifo_count;
    logic [1:0]            occ;
    logic                  can_issue;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [DATA_WIDTH-1:0] push_elem;

    assign pop = out_valid && out_ready;

    // Credit check: FIFO entries plus the element in flight must leave room for one more,
    // counting the slot freed by a pop this cycle so a row streams at one element per cycle.
    always_comb begin
        occ       = fifo_count + {1'b0, inflight_q};
        can_issue = (occ < 2'd2) || ((occ == 2'd2) && pop);
    end

    // Next-state logic for the run FSM, address counters and read pipeline.
    always_comb begin
        state_d     = state_q;
        tok_addr_d  = tok_addr_q;
        tok_count_d = tok_count_q;
        err_d       = err_q;
        id_d        = id_q;
        idx_d       = idx_q;
        zero_d      = zero_q;
        issue       = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            EMB_IDLE: begin
                if (start) begin
                    tok_addr_d  = tok_base;
                    tok_count_d = '0;
                    err_d       = 1'b0;
                    state_d     = EMB_TOK_RD;
                end
            end
            EMB_TOK_RD: begin
                state_d = EMB_TOK_CHK;
            end
            EMB_TOK_CHK: begin
                if ((tok_data == DATA_WIDTH'(TOK_EOS)) || (tok_count_q == TOK_MAX)) begin
                    state_d = EMB_DRAIN;
                end else begin
                    id_d    = tok_data;
                    idx_d   = '0;
                    zero_d  = (32'(tok_data) >= VOCAB_SIZE);
                    if (zero_d) begin
                        err_d = 1'b1;
                    end
                    state_d = EMB_RD;
                end
            end
            EMB_RD: begin
                if (can_issue) begin
                    issue = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        tok_count_d = tok_count_q + 1'b1;
                        tok_addr_d  = tok_addr_q + 1'b1;
                        state_d     = EMB_TOK_RD;
                    end
                end
            end
            EMB_DRAIN: begin
                if ((fifo_count == 2'd0) && !inflight_q) begin
                    done    = 1'b1;
                    state_d = EMB_IDLE;
                end
            end
            default: begin
                state_d = EMB_IDLE;
            end
        endcase

        inflight_d  = issue;
        pend_last_d = issue && (idx_q == IDX_LAST);
        pend_zero_d = zero_q;
    end

    // State and datapath registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMB_IDLE;
            tok_addr_q  <= '0;
            tok_count_q <= '0;
            err_q       <= 1'b0;
            id_q        <= '0;
            idx_q       <= '0;
            zero_q      <= 1'b0;
            inflight_q  <= 1'b0;
            pend_last_q <= 1'b0;
            pend_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tok_addr_q  <= tok_addr_d;
            tok_count_q <= tok_count_d;
            err_q       <= err_d;
            id_q        <= id_d;
            idx_q       <= idx_d;
            zero_q      <= zero_d;
            inflight_q  <= inflight_d;
            pend_last_q <= pend_last_d;
            pend_zero_q <= pend_zero_d;
        end
    end

    // Out-of-vocabulary tokens never touch the SRAM; their elements are forced to zero.
    always_comb begin
        emb_addr  = zero_q ? '0 : EMB_ADDR_WIDTH'({id_q, idx_q});
        push_elem = pend_zero_q ? '0 : emb_data;
    end

    emb_out_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({pend_last_q, push_elem}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .not_empty (out_valid)
    );

    assign out_data  = fifo_head[DATA_WIDTH-1:0];
    assign out_last  = fifo_head[DATA_WIDTH];
    assign tok_addr  = tok_addr_q;
    assign tok_count = tok_count_q;
    assign err       = err_q;
    assign busy      = (state_q != EMB_IDLE);

endmodule

// File: tb/tb_token_embedder.sv
// Scoreboard bench for token_embedder: the stimulus pushes expected elements, a negedge
// monitor pops and compares every accepted element and tracks per-run statistics.
module tb_token_embedder;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int EAW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  tok_base = '0;
    logic [AW-1:0]  tok_addr;
    logic [DW-1:0]  tok_data = '0;
    logic [EAW-1:0] emb_addr;
    logic [DW-1:0]  emb_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  out_data;
    logic           out_last;
    logic           busy;
    logic           done;
    logic [AW:0]    tok_count;
    logic           err;

    token_embedder #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .EMB_DIM        (4),
        .VOCAB_SIZE     (16),
        .EMB_ADDR_WIDTH (EAW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tok_base  (tok_base),
        .tok_addr  (tok_addr),
        .tok_data  (tok_data),
        .emb_addr  (emb_addr),
        .emb_data  (emb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .tok_count (tok_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Synchronous memory models.
    logic [DW-1:0] tok_ram [16];
    logic [DW-1:0] emb_ram [256];
    always @(posedge clk) begin
        tok_data <= tok_ram[tok_addr];
        emb_data <= emb_ram[emb_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW:0] exp_q [$];
    int n_cmp = 0;
    int n_fail = 0;
    bit ready_toggle = 1'b0;

    // Per-run statistics, written only by the monitor.
    int run_start_cyc = 0;
    int run_first_valid = -1;
    int run_valid_cnt = 0;
    int run_done = 0;
    int run_done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // out_ready pattern: constant 1, or 1,0,0,1 repeating.
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_toggle) begin
                out_ready = (phase == 0) || (phase == 3);
                phase = (phase + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pop/compare, stall stability, run statistics.
    bit          prev_stall = 1'b0;
    logic [DW:0] prev_ent = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (start && !busy) begin
                run_start_cyc   = cyc;
                run_first_valid = -1;
                run_valid_cnt   = 0;
                run_done        = 0;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_last, out_data}), 32'(prev_ent));
            end
            if (out_valid) begin
                run_valid_cnt++;
                if (run_first_valid < 0) run_first_valid = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL extra_elem: got 0x%0h, expected no element",
                             {out_last, out_data});
                end else begin
                    check("elem", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                end
            end
            if (done) begin
                run_done++;
                run_done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_ent   = {out_last, out_data};
        end
    end

    task automatic push_row(input int r, input bit zero);
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] d;
            d = zero ? 8'h00 : 8'(16 * r + i);
            exp_q.push_back({(i == 3), d});
        end
    endtask

    task automatic clear_tok_ram();
        for (int a = 0; a < 16; a++) tok_ram[a] = '0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] base);
        @(posedge clk);
        #1;
        tok_base = base;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (run_done > 0) break;
        end
        if (i == budget) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
        check({name, "_done_once"}, 32'(run_done), 32'd1);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) emb_ram[a] = 8'(16 * (a / 4) + (a % 4));
        clear_tok_ram();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({tok_addr, emb_addr, out_valid, out_data, out_last}), 32'd0);
        check("rst_status", 32'({busy, done, tok_count, err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: tokens [3,5,0], out_ready=1.
        tok_ram[0] = 8'd3; tok_ram[1] = 8'd5; tok_ram[2] = 8'd0;
        push_row(3, 0); push_row(5, 0);
        pulse_start(4'd0);
        wait_done("t1", 200);
        check("t1_tok_count", 32'(tok_count), 32'd2);
        check("t1_err", 32'(err), 32'd0);
        check("t1_latency", 32'(run_first_valid - run_start_cyc), 32'd5);
        check("t1_valid_cycles", 32'(run_valid_cnt), 32'd8);

        // 2: empty run.
        clear_tok_ram();
        pulse_start(4'd0);
        wait_done("t2", 50);
        check("t2_no_valid", 32'(run_valid_cnt), 32'd0);
        check("t2_done_latency", 32'(run_done_cyc - run_start_cyc), 32'd3);
        check("t2_tok_count", 32'(tok_count), 32'd0);
        check("t2_err", 32'(err), 32'd0);

        // 3: scenario 1 under 1,0,0,1 backpressure; a start while busy must be ignored.
        tok_ram[0] = 8'd3; tok_ram[1] = 8'd5; tok_ram[2] = 8'd0;
        tok_ram[9] = 8'd7;
        ready_toggle = 1'b1;
        push_row(3, 0); push_row(5, 0);
        pulse_start(4'd0);
        repeat (4) @(posedge clk);
        pulse_start(4'd9);
        wait_done("t3", 300);
        check("t3_tok_count", 32'(tok_count), 32'd2);
        ready_toggle = 1'b0;

        // 4: address wrap from 14.
        clear_tok_ram();
        tok_ram[14] = 8'd2; tok_ram[15] = 8'd7; tok_ram[0] = 8'd0;
        push_row(2, 0); push_row(7, 0);
        pulse_start(4'd14);
        wait_done("t4", 200);
        check("t4_tok_count", 32'(tok_count), 32'd2);
        check("t4_tok_addr_wrap", 32'(tok_addr), 32'd0);

        // 5: out-of-vocabulary token.
        clear_tok_ram();
        tok_ram[0] = 8'd20; tok_ram[1] = 8'd1; tok_ram[2] = 8'd0;
        push_row(20, 1); push_row(1, 0);
        pulse_start(4'd0);
        wait_done("t5", 200);
        check("t5_err", 32'(err), 32'd1);
        check("t5_tok_count", 32'(tok_count), 32'd2);
        repeat (5) @(negedge clk);
        check("t5_err_sticky", 32'(err), 32'd1);

        // 6: reset in the middle of row 2, then a clean replay.
        clear_tok_ram();
        tok_ram[0] = 8'd3; tok_ram[1] = 8'd5; tok_ram[2] = 8'd0;
        push_row(3, 0); push_row(5, 0);
        pulse_start(4'd0);
        check("t6_err_cleared", 32'(err), 32'd0);
        begin
            int i;
            for (i = 0; i < 100; i++) begin
                @(negedge clk);
                if (out_valid && out_data == 8'h51) break;
            end
            if (i == 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL t6_reach_row2: got no 0x51 element, expected it within 100 cycles");
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", 32'({tok_addr, emb_addr, out_valid, out_data, out_last}), 32'd0);
        check("t6_rst_status", 32'({busy, done, tok_count, err}), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_no_done", 32'(run_done), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        push_row(3, 0); push_row(5, 0);
        pulse_start(4'd0);
        wait_done("t6", 200);
        check("t6_tok_count", 32'(tok_count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
